smart_house_zoned: RTL and testbench

Parametrised successor of the single-room smart-house controller. Drives music, curtain, light and window for the house and independent cooler/heater pairs for `ZONES` climate zones. Climate control uses hysteresis thresholds with a window interlock. Window control uses a handshaked passcode matcher with failed-attempt lockout, and a ring request temporarily mutes music. Sits directly under the top-level house design, fed by sensor and keypad front-ends.

---
 rtl/smart_house_pkg.sv | 42 ++++
 rtl/smart_house_zoned_code_matcher.sv | 112 +++++++++++
 rtl/smart_house_zoned.sv | 152 +++++++++++++++
 tb/tb_smart_house_zoned.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/smart_house_pkg.sv
`default_nettype none
// ============================================================================
// Module   : smart_house_pkg
// Purpose  : Shared types and constants for the zoned smart-house controller:
//            climate state encoding, passcode matcher state encoding,
//            the default passcode and ASCII helper constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package smart_house_pkg;

    // Per-zone climate controller state
    typedef enum logic [1:0] {
        CLIM_OFF  = 2'd0,
        CLIM_COOL = 2'd1,
        CLIM_HEAT = 2'd2
    } clim_state_t;

    // Passcode matcher state
    typedef enum logic {
        MATCH_ACTIVE = 1'b0,
        MATCH_LOCKED = 1'b1
    } match_state_t;

    localparam int                              c_DEFAULT_CODE_LEN = 10;
    localparam logic [8*c_DEFAULT_CODE_LEN-1:0] c_DEFAULT_CODE     = "OPENWINDOW";

    localparam logic [7:0] c_ASCII_D = 8'h44;
    localparam logic [7:0] c_ASCII_E = 8'h45;
    localparam logic [7:0] c_ASCII_I = 8'h49;
    localparam logic [7:0] c_ASCII_N = 8'h4E;
    localparam logic [7:0] c_ASCII_O = 8'h4F;
    localparam logic [7:0] c_ASCII_P = 8'h50;
    localparam logic [7:0] c_ASCII_W = 8'h57;

    // Counter width able to hold values 0..v-1, never narrower than one bit
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage : smart_house_pkg
`default_nettype wire

// File: rtl/smart_house_zoned_code_matcher.sv
`default_nettype none
// ============================================================================
// Module   : code_matcher
// Purpose  : Keypad passcode matcher with failed-attempt lockout.
//            o_match pulses (combinationally, in the cycle of the final
//            character) when the full code has been entered; the owner of
//            the controlled register samples it on the same edge.
// Ports    : i_clk        - clock, rising edge
//            i_rst_n      - asynchronous active-low reset
//            i_char_valid - i_char is valid this cycle
//            i_char       - ASCII character
//            o_match      - full code completed this cycle
//            o_locked     - lockout active (registered state)
// Revision : 1.0 - initial release
// ============================================================================
module code_matcher
    import smart_house_pkg::*;
#(
    parameter int                    CODE_LEN    = c_DEFAULT_CODE_LEN,
    parameter logic [8*CODE_LEN-1:0] CODE        = c_DEFAULT_CODE,
    parameter int                    MAX_FAIL    = 3,
    parameter int                    LOCK_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_char_valid,
    input  logic [7:0] i_char,
    output logic       o_match,
    output logic       o_locked
);

    localparam int c_IDX_W  = clog2_min1(CODE_LEN);
    localparam int c_FAIL_W = clog2_min1(MAX_FAIL + 1);
    localparam int c_LOCK_W = clog2_min1(LOCK_CYCLES + 1);

    match_state_t          r_state,    w_state_next;
    logic [c_IDX_W-1:0]    r_idx,      w_idx_next;
    logic [c_FAIL_W-1:0]   r_fail,     w_fail_next;
    logic [c_LOCK_W-1:0]   r_lock_cnt, w_lock_next;
    logic [7:0]            w_code_chars [CODE_LEN];
    logic [7:0]            w_expect;
    logic                  w_match;

    // Split the MSB-first packed code into per-position characters
    for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_chars
        assign w_code_chars[gi] = CODE[8*(CODE_LEN-1-gi) +: 8];
    end

    assign w_expect = w_code_chars[r_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= MATCH_ACTIVE;
            r_idx      <= '0;
            r_fail     <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_fail     <= w_fail_next;
            r_lock_cnt <= w_lock_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_fail_next  = r_fail;
        w_lock_next  = r_lock_cnt;
        w_match      = 1'b0;
        case (r_state)
            MATCH_LOCKED: begin
                // Characters are ignored for the whole lockout
                if (r_lock_cnt <= c_LOCK_W'(1)) begin
                    w_state_next = MATCH_ACTIVE;
                    w_lock_next  = '0;
                end else begin
                    w_lock_next  = r_lock_cnt - c_LOCK_W'(1);
                end
            end
            default: begin
                if (i_char_valid) begin
                    if (i_char == w_expect) begin
                        if (r_idx == c_IDX_W'(CODE_LEN - 1)) begin
                            w_match     = 1'b1;
                            w_idx_next  = '0;
                            w_fail_next = '0;
                        end else begin
                            w_idx_next  = r_idx + c_IDX_W'(1);
                        end
                    end else if (r_idx != '0) begin
                        if (r_fail == c_FAIL_W'(MAX_FAIL - 1)) begin
                            w_state_next = MATCH_LOCKED;
                            w_lock_next  = c_LOCK_W'(LOCK_CYCLES);
                            w_idx_next   = '0;
                            w_fail_next  = '0;
                        end else begin
                            w_fail_next  = r_fail + c_FAIL_W'(1);
                            // A wrong char may itself start a fresh attempt
                            w_idx_next   = (i_char == w_code_chars[0]) ? c_IDX_W'(1) : '0;
                        end
                    end
                end
            end
        endcase
    end

    assign o_match  = w_match;
    assign o_locked = (r_state == MATCH_LOCKED);

endmodule : code_matcher
`default_nettype wire

// File: rtl/smart_house_zoned.sv
`default_nettype none
// ============================================================================
// Module   : smart_house_zoned
// Purpose  : House controller: music (muted after a doorbell ring), curtain,
//            light, passcode-operated window, and per-zone cooler/heater
//            with hysteresis and a window interlock.
// Ports    : clock, reset (async active-low)
//            isday, music_req, light_req, curtain_req, ring_req
//            temp_req  [ZONES*TEMP_W] signed zone temperatures
//            char_valid, char_req[8] keypad input
//            music, curtain, light, window, locked, cooler[ZONES], heater[ZONES]
// Revision : 1.0 - initial release
// ============================================================================
module smart_house_zoned
    import smart_house_pkg::*;
#(
    parameter int                    ZONES       = 4,
    parameter int                    TEMP_W      = 16,
    parameter int                    CODE_LEN    = c_DEFAULT_CODE_LEN,
    parameter logic [8*CODE_LEN-1:0] CODE        = c_DEFAULT_CODE,
    parameter int                    T_HIGH      = 30,
    parameter int                    T_LOW       = 15,
    parameter int                    HYST        = 2,
    parameter int                    MAX_FAIL    = 3,
    parameter int                    LOCK_CYCLES = 64,
    parameter int                    RING_CYCLES = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    isday,
    input  logic                    music_req,
    input  logic                    light_req,
    input  logic                    curtain_req,
    input  logic                    ring_req,
    input  logic [ZONES*TEMP_W-1:0] temp_req,
    input  logic                    char_valid,
    input  logic [7:0]              char_req,
    output logic                    music,
    output logic                    curtain,
    output logic                    light,
    output logic                    window,
    output logic                    locked,
    output logic [ZONES-1:0]        cooler,
    output logic [ZONES-1:0]        heater
);

    localparam int c_RING_W = clog2_min1(RING_CYCLES + 1);

    localparam logic signed [TEMP_W-1:0] c_COOL_ON  = TEMP_W'(T_HIGH);
    localparam logic signed [TEMP_W-1:0] c_COOL_OFF = TEMP_W'(T_HIGH - HYST);
    localparam logic signed [TEMP_W-1:0] c_HEAT_ON  = TEMP_W'(T_LOW);
    localparam logic signed [TEMP_W-1:0] c_HEAT_OFF = TEMP_W'(T_LOW + HYST);

    logic                r_music;
    logic                r_curtain;
    logic                r_light;
    logic                r_window;
    logic [c_RING_W-1:0] r_ring_cnt;
    logic                w_match;
    logic                w_locked;

    code_matcher #(
        .CODE_LEN    (CODE_LEN),
        .CODE        (CODE),
        .MAX_FAIL    (MAX_FAIL),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_code_matcher (
        .i_clk        (clock),
        .i_rst_n      (reset),
        .i_char_valid (char_valid),
        .i_char       (char_req),
        .o_match      (w_match),
        .o_locked     (w_locked)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_music    <= 1'b0;
            r_curtain  <= 1'b0;
            r_light    <= 1'b0;
            r_window   <= 1'b0;
            r_ring_cnt <= '0;
        end else begin
            r_light    <= light_req | ~isday;
            r_curtain  <= curtain_req & isday;
            r_music    <= music_req & (r_ring_cnt == '0);
            r_window   <= r_window ^ w_match;
            if (ring_req) begin
                r_ring_cnt <= c_RING_W'(RING_CYCLES);
            end else if (r_ring_cnt != '0) begin
                r_ring_cnt <= r_ring_cnt - c_RING_W'(1);
            end
        end
    end

    for (genvar gz = 0; gz < ZONES; gz++) begin : g_zone
        clim_state_t               r_state;
        clim_state_t               w_next;
        logic signed [TEMP_W-1:0]  w_temp;

        assign w_temp = temp_req[gz*TEMP_W +: TEMP_W];

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_state <= CLIM_OFF;
            end else begin
                r_state <= w_next;
            end
        end

        // COOL and HEAT only ever exit to OFF, so a mode swap always
        // spends at least one cycle idle.
        always_comb begin
            w_next = r_state;
            if (r_window) begin
                w_next = CLIM_OFF;
            end else begin
                case (r_state)
                    CLIM_OFF: begin
                        if (w_temp > c_COOL_ON) begin
                            w_next = CLIM_COOL;
                        end else if (w_temp < c_HEAT_ON) begin
                            w_next = CLIM_HEAT;
                        end
                    end
                    CLIM_COOL: begin
                        if (w_temp <= c_COOL_OFF) begin
                            w_next = CLIM_OFF;
                        end
                    end
                    CLIM_HEAT: begin
                        if (w_temp >= c_HEAT_OFF) begin
                            w_next = CLIM_OFF;
                        end
                    end
                    default: w_next = CLIM_OFF;
                endcase
            end
        end

        assign cooler[gz] = (r_state == CLIM_COOL);
        assign heater[gz] = (r_state == CLIM_HEAT);
    end

    assign music   = r_music;
    assign curtain = r_curtain;
    assign light   = r_light;
    assign window  = r_window;
    assign locked  = w_locked;

endmodule : smart_house_zoned
`default_nettype wire

// File: tb/tb_smart_house_zoned.sv
`default_nettype none
// ============================================================================
// Module   : tb_smart_house_zoned
// Purpose  : Self-checking bench for smart_house_zoned. A cycle-level
//            behavioural model built from the operating rules predicts every
//            output each clock; directed steps add explicit expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smart_house_zoned;

    localparam int ZONES       = 4;
    localparam int TEMP_W      = 16;
    localparam int CODE_LEN    = 10;
    localparam int T_HIGH      = 30;
    localparam int T_LOW       = 15;
    localparam int HYST        = 2;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 64;
    localparam int RING_CYCLES = 16;
    localparam logic [8*CODE_LEN-1:0] c_CODE = "OPENWINDOW";

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic                    isday, music_req, light_req, curtain_req, ring_req;
    logic [ZONES*TEMP_W-1:0] temp_req;
    logic                    char_valid;
    logic [7:0]              char_req;
    logic                    music, curtain, light, window, locked;
    logic [ZONES-1:0]        cooler, heater;

    smart_house_zoned #(
        .ZONES(ZONES), .TEMP_W(TEMP_W), .CODE_LEN(CODE_LEN), .CODE(c_CODE),
        .T_HIGH(T_HIGH), .T_LOW(T_LOW), .HYST(HYST), .MAX_FAIL(MAX_FAIL),
        .LOCK_CYCLES(LOCK_CYCLES), .RING_CYCLES(RING_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .isday(isday), .music_req(music_req),
        .light_req(light_req), .curtain_req(curtain_req), .ring_req(ring_req),
        .temp_req(temp_req), .char_valid(char_valid), .char_req(char_req),
        .music(music), .curtain(curtain), .light(light), .window(window),
        .locked(locked), .cooler(cooler), .heater(heater)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    string code_s = "OPENWINDOW";
    int    m_ring, m_lock, m_idx, m_fail;
    int    m_zone [ZONES];   // 0 idle, 1 cooling, 2 heating
    bit    m_window, m_music, m_light, m_curtain;

    function automatic void model_reset();
        m_ring = 0; m_lock = 0; m_idx = 0; m_fail = 0;
        m_window = 0; m_music = 0; m_light = 0; m_curtain = 0;
        for (int z = 0; z < ZONES; z++) m_zone[z] = 0;
    endfunction

    function automatic void model_edge();
        int  t;
        bit  toggle;
        toggle    = 0;
        m_light   = light_req | ~isday;
        m_curtain = curtain_req & isday;
        m_music   = music_req && (m_ring == 0);
        if (ring_req) m_ring = RING_CYCLES;
        else if (m_ring > 0) m_ring = m_ring - 1;

        for (int z = 0; z < ZONES; z++) begin
            t = int'($signed(temp_req[z*TEMP_W +: TEMP_W]));
            if (m_window) m_zone[z] = 0;
            else if (m_zone[z] == 0) begin
                if (t > T_HIGH) m_zone[z] = 1;
                else if (t < T_LOW) m_zone[z] = 2;
            end else if (m_zone[z] == 1) begin
                if (t <= T_HIGH - HYST) m_zone[z] = 0;
            end else begin
                if (t >= T_LOW + HYST) m_zone[z] = 0;
            end
        end

        if (m_lock > 0) begin
            m_lock = m_lock - 1;
        end else if (char_valid) begin
            if (char_req == code_s[m_idx]) begin
                m_idx = m_idx + 1;
                if (m_idx == CODE_LEN) begin
                    toggle = 1; m_idx = 0; m_fail = 0;
                end
            end else if (m_idx > 0) begin
                m_fail = m_fail + 1;
                m_idx  = (char_req == code_s[0]) ? 1 : 0;
                if (m_fail == MAX_FAIL) begin
                    m_lock = LOCK_CYCLES; m_idx = 0; m_fail = 0;
                end
            end
        end
        if (toggle) m_window = !m_window;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [ZONES-1:0] ec, eh;
        for (int z = 0; z < ZONES; z++) begin
            ec[z] = (m_zone[z] == 1);
            eh[z] = (m_zone[z] == 2);
        end
        chk("music",   {31'd0, music},   {31'd0, m_music});
        chk("curtain", {31'd0, curtain}, {31'd0, m_curtain});
        chk("light",   {31'd0, light},   {31'd0, m_light});
        chk("window",  {31'd0, window},  {31'd0, m_window});
        chk("locked",  {31'd0, locked},  {31'd0, (m_lock > 0)});
        chk("cooler",  32'(cooler), 32'(ec));
        chk("heater",  32'(heater), 32'(eh));
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_temp(input int z, input int t);
        temp_req[z*TEMP_W +: TEMP_W] = TEMP_W'(t);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            char_valid = 1'b1;
            char_req   = s[i];
            cyc();
            char_valid = 1'b0;
            if (i != s.len() - 1) repeat (gap) cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string alpha;
        int    k;
        alpha = "OPENWDIX";
        isday = 1; music_req = 0; light_req = 0; curtain_req = 0; ring_req = 0;
        char_valid = 0; char_req = 8'h00;
        for (int z = 0; z < ZONES; z++) set_temp(z, 20);
        model_reset();

        // Power-on reset
        #2;
        check_all();
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (3) cyc();

        // Doorbell mute: ring at cycle 0 and cycle 10
        music_req = 1;
        cyc();
        chk("music_before_ring", {31'd0, music}, 32'd1);
        ring_req = 1;
        cyc();
        for (int c = 1; c <= 27; c++) begin
            ring_req = (c == 10);
            cyc();
            chk("music_mute", {31'd0, music}, (c == 27) ? 32'd1 : 32'd0);
        end
        ring_req = 0;

        // Climate zones with hysteresis boundaries
        set_temp(0, -5); set_temp(2, 25);
        cyc();
        chk("z0_heat", 32'(heater), 32'b0001);
        chk("z2_25",   32'(cooler), 32'b0000);
        set_temp(2, 35); cyc(); chk("z2_35", 32'(cooler), 32'b0100);
        set_temp(2, 29); cyc(); chk("z2_29", 32'(cooler), 32'b0100);
        set_temp(2, 27); cyc(); chk("z2_27", 32'(cooler), 32'b0000);
        set_temp(2, 30); cyc(); chk("z2_30", 32'(cooler), 32'b0000);
        set_temp(2, 31); cyc(); chk("z2_31", 32'(cooler), 32'b0100);
        set_temp(2, 28); cyc(); chk("z2_28", 32'(cooler), 32'b0000);
        set_temp(1, 15); cyc(); chk("z1_15", 32'(heater), 32'b0001);
        set_temp(1, 14); cyc(); chk("z1_14", 32'(heater), 32'b0011);
        set_temp(0, 16); cyc(); chk("z0_16", 32'(heater), 32'b0011);
        set_temp(0, 17); cyc(); chk("z0_17", 32'(heater), 32'b0010);
        set_temp(0, -5); set_temp(2, 35); cyc(); cyc();

        // Window open with gaps, then interlock
        send_str("OPENWINDOW", 2);
        chk("window_open", {31'd0, window}, 32'd1);
        cyc();
        chk("interlock_cool", 32'(cooler), 32'd0);
        chk("interlock_heat", 32'(heater), 32'd0);
        set_temp(2, 40); cyc(); cyc();
        chk("interlock_40", 32'(cooler), 32'd0);
        send_str("OPENWINDOW", 0);
        chk("window_close", {31'd0, window}, 32'd0);
        repeat (2) cyc();

        // Lockout
        send_str("OPXOPXOPX", 1);
        chk("locked_on", {31'd0, locked}, 32'd1);
        send_str("OPENWINDOW", 0);
        chk("window_locked", {31'd0, window}, 32'd0);
        for (k = 0; k < 100 && locked; k++) cyc();
        chk("lock_len", 32'(10 + k), 32'(LOCK_CYCLES));
        send_str("OPENWINDOW", 0);
        chk("window_after_lock", {31'd0, window}, 32'd1);

        // Restart on repeated first char, failure count clears on success
        send_str("OOPENWINDOW", 1);
        chk("window_restart", {31'd0, window}, 32'd0);
        send_str("OPXOPX", 0);
        chk("fail_cleared", {31'd0, locked}, 32'd0);
        send_str("OPENWINDOW", 0);
        chk("window_reopen", {31'd0, window}, 32'd1);

        // Asynchronous reset mid-run, at night with curtain requested
        isday = 0; curtain_req = 1; ring_req = 1; char_valid = 1; char_req = "O";
        cyc();
        ring_req = 0; char_valid = 0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clock); #1;
        check_all();
        reset = 1'b1;
        cyc();
        chk("rst_curtain", {31'd0, curtain}, 32'd0);
        chk("rst_light",   {31'd0, light},   32'd1);
        chk("rst_window",  {31'd0, window},  32'd0);
        repeat (3) cyc();

        // Randomised traffic against the model
        for (int i = 0; i < 500; i++) begin
            isday       = 1'($urandom_range(0, 1));
            music_req   = 1'($urandom_range(0, 1));
            light_req   = 1'($urandom_range(0, 1));
            curtain_req = 1'($urandom_range(0, 1));
            ring_req    = ($urandom_range(0, 19) == 0);
            for (int z = 0; z < ZONES; z++)
                if ($urandom_range(0, 3) == 0) set_temp(z, int'($urandom_range(0, 50)) - 10);
            char_valid  = 1'($urandom_range(0, 1));
            char_req    = alpha[$urandom_range(0, 7)];
            cyc();
            if (i % 60 == 30) begin
                ring_req = 0;
                send_str("OPENWINDOW", 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_smart_house_zoned
`default_nettype wire
